// File: rtl/sevseg_scan_decoder.sv
// sevseg_scan_decoder: samples a scanned an/seg bus, demultiplexes four digits and decodes them to hex
module sevseg_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an_in,
  input  logic [7:0]  seg_in,
  output logic [31:0] digits_raw,
  output logic [15:0] digits_hex,
  output logic [3:0]  hex_valid,
  output logic [3:0]  dp_lit,
  output logic        frame_done,
  output logic        scan_error
);
  logic [3:0] s1_an, s2_an, seen, hit;
  logic [7:0] s1_seg, s2_seg, run, run_next;
  logic [7:0] digit [4];
  logic       prev_valid, accept, onehot, blank;
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h40: decode = 5'h10;
      7'h79: decode = 5'h11;
      7'h24: decode = 5'h12;
      7'h30: decode = 5'h13;
      7'h19: decode = 5'h14;
      7'h12: decode = 5'h15;
      7'h02: decode = 5'h16;
      7'h78: decode = 5'h17;
      7'h00: decode = 5'h18;
      7'h10: decode = 5'h19;
      7'h08: decode = 5'h1A;
      7'h03: decode = 5'h1B;
      7'h46: decode = 5'h1C;
      7'h21: decode = 5'h1D;
      7'h06: decode = 5'h1E;
      7'h0E: decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction
  // accept fires only on the cycle the run first reaches the threshold, so a long dwell writes once
  always_comb begin
    run_next = (prev_valid && {s1_an, s1_seg} == {s2_an, s2_seg}) ? ((run == 8'hFF) ? 8'hFF : run + 8'd1) : 8'd1;
    accept   = run_next == 8'(SETTLE_CYCLES);
    hit      = ~s1_an;
    onehot   = s1_an inside {4'b1110, 4'b1101, 4'b1011, 4'b0111};
    blank    = s1_an == 4'hF;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_an      <= 4'hF;
      s1_seg     <= 8'hFF;
      s2_an      <= 4'hF;
      s2_seg     <= 8'hFF;
      run        <= 8'd0;
      prev_valid <= 1'b0;
      seen       <= 4'h0;
      frame_done <= 1'b0;
      scan_error <= 1'b0;
      for (int i = 0; i < 4; i++) digit[i] <= 8'hFF;
    end else begin
      s1_an      <= an_in;
      s1_seg     <= seg_in;
      s2_an      <= s1_an;
      s2_seg     <= s1_seg;
      run        <= run_next;
      prev_valid <= 1'b1;
      frame_done <= 1'b0;
      scan_error <= 1'b0;
      if (accept && onehot) begin
        for (int i = 0; i < 4; i++) if (hit[i]) digit[i] <= s1_seg;
        if ((seen | hit) == 4'hF) begin
          frame_done <= 1'b1;
          seen       <= 4'h0;
        end else seen <= seen | hit;
      end else if (accept && !blank) begin
        scan_error <= 1'b1;
        seen       <= 4'h0;
      end
    end
  end
  for (genvar g = 0; g < 4; g++) begin : g_digit
    assign digits_raw[8*g +: 8]              = digit[g];
    assign dp_lit[g]                         = ~digit[g][7];
    assign {hex_valid[g], digits_hex[4*g +: 4]} = decode(digit[g][6:0]);
  end
endmodule
